// File: rtl/pci_master_sched.sv
// Round-robin scheduler sharing the PCI master bus engine between the write and read
// command paths; one transaction outstanding, write-buffer indexing and completion routing.
module pci_master_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wr_cmd_id,
    input  logic [7:0]  wr_cmd_len,
    input  logic [63:0] wr_cmd_addr,
    input  logic        wr_cmd_valid,
    output logic        wr_cmd_ready,
    input  logic [3:0]  rd_cmd_id,
    input  logic [7:0]  rd_cmd_len,
    input  logic [63:0] rd_cmd_addr,
    input  logic        rd_cmd_valid,
    output logic        rd_cmd_ready,
    output logic [9:0]  data_idx,
    input  logic [31:0] data_dout,
    input  logic [3:0]  data_strb,
    output logic        eng_cmd_write,
    output logic [3:0]  eng_cmd_id,
    output logic [7:0]  eng_cmd_len,
    output logic [63:0] eng_cmd_addr,
    output logic        eng_cmd_valid,
    input  logic        eng_cmd_ready,
    output logic [31:0] eng_wdata,
    output logic [3:0]  eng_wstrb,
    input  logic        eng_data_next,
    input  logic [3:0]  eng_resp_id,
    input  logic [7:0]  eng_resp_len,
    input  logic [1:0]  eng_resp_err,
    input  logic        eng_resp_valid,
    output logic        eng_resp_ready,
    output logic [3:0]  wr_resp_id,
    output logic [7:0]  wr_resp_len,
    output logic [1:0]  wr_resp_err,
    output logic        wr_resp_valid,
    input  logic        wr_resp_ready,
    output logic [3:0]  rd_resp_id,
    output logic [7:0]  rd_resp_len,
    output logic [1:0]  rd_resp_err,
    output logic        rd_resp_valid,
    input  logic        rd_resp_ready,
    output logic        beat_ovf
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    state_t      state_q, state_d;
    logic        cur_write_q, last_wr_q;
    logic [3:0]  cmd_id_q;
    logic [7:0]  cmd_len_q;
    logic [63:0] cmd_addr_q;
    logic [9:0]  wr_base_q;
    logic [7:0]  wr_off_q;
    logic        wr_last_q;
    logic        beat_ovf_q;
    logic        resp_fire;

    always_comb begin
        state_d        = state_q;
        wr_cmd_ready   = 1'b0;
        rd_cmd_ready   = 1'b0;
        eng_resp_ready = 1'b0;
        wr_resp_valid  = 1'b0;
        rd_resp_valid  = 1'b0;
        resp_fire      = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_cmd_valid && (!rd_cmd_valid || !last_wr_q)) begin
                    wr_cmd_ready = 1'b1;
                    state_d      = ISSUE;
                end else if (rd_cmd_valid) begin
                    rd_cmd_ready = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (eng_cmd_ready) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (cur_write_q) begin
                    wr_resp_valid  = eng_resp_valid;
                    eng_resp_ready = wr_resp_ready;
                end else begin
                    rd_resp_valid  = eng_resp_valid;
                    eng_resp_ready = rd_resp_ready;
                end
                resp_fire = eng_resp_valid && (cur_write_q ? wr_resp_ready : rd_resp_ready);
                if (resp_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_write_q <= 1'b0;
            last_wr_q   <= 1'b0;
            cmd_id_q    <= '0;
            cmd_len_q   <= '0;
            cmd_addr_q  <= '0;
            wr_base_q   <= '0;
            wr_off_q    <= '0;
            wr_last_q   <= 1'b0;
            beat_ovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_cmd_ready || rd_cmd_ready) begin
                cur_write_q <= wr_cmd_ready;
                last_wr_q   <= wr_cmd_ready;
                cmd_id_q    <= wr_cmd_ready ? wr_cmd_id   : rd_cmd_id;
                cmd_len_q   <= wr_cmd_ready ? wr_cmd_len  : rd_cmd_len;
                cmd_addr_q  <= wr_cmd_ready ? wr_cmd_addr : rd_cmd_addr;
                wr_off_q    <= '0;
                wr_last_q   <= 1'b0;
            end else if (state_q != IDLE && cur_write_q && eng_data_next) begin
                // The pulse at saturation consumes the final beat; only a pulse after it overflows.
                if (wr_last_q)
                    beat_ovf_q <= 1'b1;
                else if (wr_off_q == cmd_len_q)
                    wr_last_q <= 1'b1;
                else
                    wr_off_q <= wr_off_q + 8'd1;
            end
            if (resp_fire && cur_write_q)
                wr_base_q <= wr_base_q + {2'b00, cmd_len_q} + 10'd1;
        end
    end

    assign data_idx      = wr_base_q + {2'b00, wr_off_q};
    assign eng_cmd_write = cur_write_q;
    assign eng_cmd_id    = cmd_id_q;
    assign eng_cmd_len   = cmd_len_q;
    assign eng_cmd_addr  = cmd_addr_q;
    assign eng_cmd_valid = (state_q == ISSUE);
    assign eng_wdata     = data_dout;
    assign eng_wstrb     = data_strb;
    assign wr_resp_id    = eng_resp_id;
    assign wr_resp_len   = eng_resp_len;
    assign wr_resp_err   = eng_resp_err;
    assign rd_resp_id    = eng_resp_id;
    assign rd_resp_len   = eng_resp_len;
    assign rd_resp_err   = eng_resp_err;
    assign beat_ovf      = beat_ovf_q;

endmodule

// File: tb/tb_pci_master_sched.sv
// Randomized self-checking bench for pci_master_sched against a transaction-level model.
module tb_pci_master_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wr_cmd_id, rd_cmd_id, eng_cmd_id, eng_resp_id, wr_resp_id, rd_resp_id;
    logic [7:0]  wr_cmd_len, rd_cmd_len, eng_cmd_len, eng_resp_len, wr_resp_len, rd_resp_len;
    logic [63:0] wr_cmd_addr, rd_cmd_addr, eng_cmd_addr;
    logic        wr_cmd_valid, wr_cmd_ready, rd_cmd_valid, rd_cmd_ready;
    logic [9:0]  data_idx;
    logic [31:0] data_dout, eng_wdata;
    logic [3:0]  data_strb, eng_wstrb;
    logic        eng_cmd_write, eng_cmd_valid, eng_cmd_ready, eng_data_next;
    logic [1:0]  eng_resp_err, wr_resp_err, rd_resp_err;
    logic        eng_resp_valid, eng_resp_ready;
    logic        wr_resp_valid, wr_resp_ready, rd_resp_valid, rd_resp_ready;
    logic        beat_ovf;

    pci_master_sched dut (
        .clk(clk), .rst(rst),
        .wr_cmd_id(wr_cmd_id), .wr_cmd_len(wr_cmd_len), .wr_cmd_addr(wr_cmd_addr),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
        .rd_cmd_id(rd_cmd_id), .rd_cmd_len(rd_cmd_len), .rd_cmd_addr(rd_cmd_addr),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .data_idx(data_idx), .data_dout(data_dout), .data_strb(data_strb),
        .eng_cmd_write(eng_cmd_write), .eng_cmd_id(eng_cmd_id), .eng_cmd_len(eng_cmd_len),
        .eng_cmd_addr(eng_cmd_addr), .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
        .eng_wdata(eng_wdata), .eng_wstrb(eng_wstrb), .eng_data_next(eng_data_next),
        .eng_resp_id(eng_resp_id), .eng_resp_len(eng_resp_len), .eng_resp_err(eng_resp_err),
        .eng_resp_valid(eng_resp_valid), .eng_resp_ready(eng_resp_ready),
        .wr_resp_id(wr_resp_id), .wr_resp_len(wr_resp_len), .wr_resp_err(wr_resp_err),
        .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready),
        .rd_resp_id(rd_resp_id), .rd_resp_len(rd_resp_len), .rd_resp_err(rd_resp_err),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
        .beat_ovf(beat_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: write-buffer base slot, which source won last, sticky overflow.
    int m_base;
    bit m_last_wr;
    bit m_ovf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_cmd_valid = 0; wr_cmd_id = '0; wr_cmd_len = '0; wr_cmd_addr = '0;
        rd_cmd_valid = 0; rd_cmd_id = '0; rd_cmd_len = '0; rd_cmd_addr = '0;
        data_dout = '0; data_strb = '0;
        eng_cmd_ready = 0; eng_data_next = 0;
        eng_resp_valid = 0; eng_resp_id = '0; eng_resp_len = '0; eng_resp_err = '0;
        wr_resp_ready = 0; rd_resp_ready = 0;
    endtask

    task automatic apply_reset();
        rst = 1;
        idle_inputs();
        tick();
        #1;
        check("rst_cmd_valid", eng_cmd_valid, 0);
        check("rst_cmd_write", eng_cmd_write, 0);
        check("rst_cmd_id",    eng_cmd_id,    0);
        check("rst_cmd_len",   eng_cmd_len,   0);
        check("rst_cmd_addr",  eng_cmd_addr,  0);
        check("rst_data_idx",  data_idx,      0);
        check("rst_beat_ovf",  beat_ovf,      0);
        check("rst_wr_ready",  wr_cmd_ready,  0);
        check("rst_rd_ready",  rd_cmd_ready,  0);
        check("rst_resp_rdy",  eng_resp_ready, 0);
        check("rst_wr_rvalid", wr_resp_valid, 0);
        check("rst_rd_rvalid", rd_resp_valid, 0);
        rst = 0;
        m_base = 0; m_last_wr = 0; m_ovf = 0;
    endtask

    // One full transaction; when rst_mid is set, reset is asserted after the beats instead of completing.
    task automatic txn(input bit wv, input bit rv, input int wl, input int rl, input int pulses,
                       input int cmd_delay, input int resp_stall, input bit rst_mid);
        bit          gw;
        int          len, pc, k;
        logic [3:0]  exp_id, r_id;
        logic [7:0]  r_len;
        logic [1:0]  r_err;
        logic [63:0] exp_addr;
        gw = wv && (!rv || !m_last_wr);
        wr_cmd_valid = wv; wr_cmd_id = 4'($urandom); wr_cmd_len = 8'(wl);
        wr_cmd_addr = {$urandom, $urandom};
        rd_cmd_valid = rv; rd_cmd_id = 4'($urandom); rd_cmd_len = 8'(rl);
        rd_cmd_addr = {$urandom, $urandom};
        data_dout = $urandom; data_strb = 4'($urandom);
        len      = gw ? wl : rl;
        exp_id   = gw ? wr_cmd_id : rd_cmd_id;
        exp_addr = gw ? wr_cmd_addr : rd_cmd_addr;
        #1;
        check("grant_wr", wr_cmd_ready, gw);
        check("grant_rd", rd_cmd_ready, !gw);
        check("wdata_pass", eng_wdata, data_dout);
        check("wstrb_pass", eng_wstrb, data_strb);
        check("cmdv_idle", eng_cmd_valid, 0);
        tick();
        wr_cmd_valid = 0; rd_cmd_valid = 0;
        #1;
        check("cmd_valid", eng_cmd_valid, 1);
        check("cmd_write", eng_cmd_write, gw);
        check("cmd_id",    eng_cmd_id,    exp_id);
        check("cmd_len",   eng_cmd_len,   len);
        check("cmd_addr",  eng_cmd_addr,  exp_addr);
        check("idx_start", data_idx,      m_base);
        check("ovf_keep",  beat_ovf,      m_ovf);
        for (int i = 0; i < cmd_delay; i++) begin
            eng_resp_valid = 1'($urandom);
            #1;
            check("resp_rdy_issue", eng_resp_ready, 0);
            check("wr_rv_issue", wr_resp_valid, 0);
            check("rd_rv_issue", rd_resp_valid, 0);
            tick();
            check("cmd_hold", eng_cmd_valid, 1);
            check("addr_hold", eng_cmd_addr, exp_addr);
        end
        eng_resp_valid = 0;
        eng_cmd_ready = 1;
        tick();
        eng_cmd_ready = 0;
        check("cmd_accepted", eng_cmd_valid, 0);
        pc = 0;
        for (int p = 0; p < pulses; p++) begin
            eng_data_next = 1;
            tick();
            eng_data_next = 0;
            pc++;
            if (gw && pc > len + 1) m_ovf = 1;
            k = gw ? ((pc > len) ? len : pc) : 0;
            check("beat_idx", data_idx, (m_base + k) % 1024);
            check("beat_ovf", beat_ovf, m_ovf);
        end
        if (rst_mid) begin
            apply_reset();
            return;
        end
        r_id = 4'($urandom); r_len = 8'($urandom); r_err = 2'($urandom);
        eng_resp_valid = 1; eng_resp_id = r_id; eng_resp_len = r_len; eng_resp_err = r_err;
        wr_resp_ready = 0; rd_resp_ready = 0;
        for (int s = 0; s < resp_stall; s++) begin
            #1;
            check("stall_rdy", eng_resp_ready, 0);
            check("stall_wr_rv", wr_resp_valid, gw);
            check("stall_rd_rv", rd_resp_valid, !gw);
            check("stall_id",  gw ? wr_resp_id  : rd_resp_id,  r_id);
            check("stall_len", gw ? wr_resp_len : rd_resp_len, r_len);
            check("stall_err", gw ? wr_resp_err : rd_resp_err, r_err);
            tick();
        end
        if (gw) begin
            wr_resp_ready = 1; rd_resp_ready = 1'($urandom);
        end else begin
            rd_resp_ready = 1; wr_resp_ready = 1'($urandom);
        end
        #1;
        check("resp_rdy", eng_resp_ready, 1);
        check("resp_wr_rv", wr_resp_valid, gw);
        check("resp_rd_rv", rd_resp_valid, !gw);
        check("resp_err", gw ? wr_resp_err : rd_resp_err, r_err);
        tick();
        if (gw) m_base = (m_base + len + 1) % 1024;
        m_last_wr = gw;
        wr_resp_ready = 1; rd_resp_ready = 1;
        #1;
        check("idle_resp_rdy", eng_resp_ready, 0);
        check("idle_wr_rv", wr_resp_valid, 0);
        check("idle_rd_rv", rd_resp_valid, 0);
        eng_resp_valid = 0; wr_resp_ready = 0; rd_resp_ready = 0;
    endtask

    initial begin
        int wl, rl, ln;
        bit wv, rv;
        apply_reset();
        // Single write, len 3: idx 0..3, base moves to 4.
        txn(1, 0, 3, 0, 4, 0, 0, 0);
        // Contention from reset: W, R, W, R.
        apply_reset();
        for (int i = 0; i < 4; i++) txn(1, 1, 2, 5, 2, 1, 1, 0);
        // Wrap: base to 1020, then len 7 runs 1020..1023,0..3 and ends at base 4.
        apply_reset();
        txn(1, 0, 255, 0, 0, 0, 0, 0);
        txn(1, 0, 255, 0, 0, 0, 0, 0);
        txn(1, 0, 255, 0, 0, 0, 0, 0);
        txn(1, 0, 251, 0, 0, 0, 0, 0);
        txn(1, 0, 7, 0, 8, 0, 0, 0);
        txn(1, 0, 0, 0, 1, 0, 0, 0);
        // Read completion back-pressured for 5 cycles.
        txn(0, 1, 0, 9, 0, 2, 5, 0);
        // Overflow on len 1 with 3 beats, sticky across later transactions.
        txn(1, 0, 1, 0, 3, 0, 0, 0);
        txn(0, 1, 0, 3, 2, 0, 1, 0);
        txn(1, 0, 0, 0, 1, 0, 0, 0);
        // Reset during WAIT_RESP, then a write starting from index 0.
        txn(1, 0, 5, 0, 2, 1, 0, 1);
        txn(1, 0, 2, 0, 3, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            wv = 1'($urandom); rv = 1'($urandom);
            if (!wv && !rv) wv = 1;
            wl = $urandom_range(0, 15); rl = $urandom_range(0, 15);
            ln = (wv && (!rv || !m_last_wr)) ? wl : rl;
            txn(wv, rv, wl, rl, $urandom_range(0, ln + 3), $urandom_range(0, 3),
                $urandom_range(0, 3), 0);
        end
        apply_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
